// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions for the SammingCPU stage registers.
// Holds the NOP bundle constants, the stage-register occupancy encoding and the
// packed stage bundles whose $bits() set the DATA_W of each pipe_stage_skid instance.
package cpu_pipe_pkg;

  // NOP bundle field values.
  localparam logic [7:0]  EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [2:0]  EXE_RES_NOP = 3'b000;
  localparam logic [4:0]  NOPRegAddr  = 5'b00000;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  // Number of valid bundles held in a stage register.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // IF/ID bundle.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  // ID/EX bundle.
  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] inst;
  } id_ex_t;

  // EX/MEM and MEM/WB bundle.
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } wb_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk    in   clock, rising edge
//   clr_i  in   synchronous clear, wins over inc_i
//   inc_i  in   count up by one this cycle
//   q_o    out  current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] q_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i && (q_q != CntMax)) begin
      q_d = q_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic inter-stage pipeline register with a 2-entry skid buffer.
// Valid/ready on both sides; main is the FIFO head, skid holds a second bundle
// so in_ready can be a pure function of occupancy. Flush empties the stage,
// an empty stage drives the NOP bundle, and a sticky side-channel plus a
// saturating bubble counter ride alongside.
// Ports:
//   clk, rst                synchronous active-high reset
//   flush_i                 drop all buffered bundles and any same-cycle input
//   in_valid_i/in_ready_o   upstream handshake, in_data_i/in_side_i captured on accept
//   out_valid_o/out_ready_i downstream handshake, out_data_o is NOP_VALUE when empty
//   out_side_o              side-channel value from the most recent accept
//   bubble_cnt_o            cycles with out_ready_i=1 and out_valid_o=0, saturating
module pipe_stage_skid
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = $bits(if_id_t),
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int unsigned       SIDE_W    = 1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [SIDE_W-1:0] in_side_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [SIDE_W-1:0] out_side_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  occ_e              occ_d, occ_q;
  logic [DATA_W-1:0] main_d, main_q;
  logic [DATA_W-1:0] skid_d, skid_q;
  logic [SIDE_W-1:0] side_d, side_q;
  logic              accept, pop;

  // Ready depends only on occupancy (and reset), never on out_ready_i, so the
  // upstream ready path is cut at this stage.
  assign in_ready_o  = ~rst & (occ_q != OCC_FULL);
  assign out_valid_o = (occ_q != OCC_EMPTY);
  assign out_data_o  = out_valid_o ? main_q : NOP_VALUE;
  assign out_side_o  = side_q;

  assign accept = in_valid_i & in_ready_o & ~flush_i;
  assign pop    = out_valid_o & out_ready_i;

  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush_i) begin
      // A same-cycle pop has already been taken downstream; nothing to undo.
      occ_d  = OCC_EMPTY;
      main_d = NOP_VALUE;
      skid_d = NOP_VALUE;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            occ_d  = OCC_ONE;
            main_d = in_data_i;
          end
        end
        OCC_ONE: begin
          if (accept && pop) begin
            main_d = in_data_i;
          end else if (accept) begin
            occ_d  = OCC_FULL;
            skid_d = in_data_i;
          end else if (pop) begin
            occ_d  = OCC_EMPTY;
            main_d = NOP_VALUE;
          end
        end
        OCC_FULL: begin
          // in_ready_o is low here, so only a pop can move the state.
          if (pop) begin
            occ_d  = OCC_ONE;
            main_d = skid_q;
            skid_d = NOP_VALUE;
          end
        end
        default: begin
          occ_d  = OCC_EMPTY;
          main_d = NOP_VALUE;
          skid_d = NOP_VALUE;
        end
      endcase
    end
  end

  // Side-channel is sticky: only an accepted bundle replaces it.
  always_comb begin
    side_d = side_q;
    if (accept) begin
      side_d = in_side_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= OCC_EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
      side_q <= '0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
      side_q <= side_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .clr_i (rst),
    .inc_i (out_ready_i & ~out_valid_o),
    .q_o   (bubble_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid. Two instances share all inputs: the main
// one with a 16-bit bubble counter and a 2-bit one for the saturation check.
module tb_pipe_stage_skid;

  localparam logic [7:0] Nop = 8'hEE;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [0:0]  in_side;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [0:0]  out_side;
  logic [15:0] bubble_cnt;

  logic        in_ready2;
  logic        out_valid2;
  logic [7:0]  out_data2;
  logic [0:0]  out_side2;
  logic [1:0]  bubble_cnt2;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(
    .DATA_W    (8),
    .NOP_VALUE (Nop),
    .SIDE_W    (1),
    .CNT_W     (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .in_side_i    (in_side),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_side_o   (out_side),
    .bubble_cnt_o (bubble_cnt)
  );

  pipe_stage_skid #(
    .DATA_W    (8),
    .NOP_VALUE (Nop),
    .SIDE_W    (1),
    .CNT_W     (2)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready2),
    .in_data_i    (in_data),
    .in_side_i    (in_side),
    .out_valid_o  (out_valid2),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data2),
    .out_side_o   (out_side2),
    .bubble_cnt_o (bubble_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_side   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, Nop);
    chk("rst_out_side", out_side, 0);
    chk("rst_bubble", bubble_cnt, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // 1: single bundle, one-cycle latency; the empty accept cycle is a bubble.
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b1;
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 8'hA5);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_bubble", bubble_cnt, 1);
    in_valid = 1'b0;
    tick();
    chk("t1_drain_valid", out_valid, 0);
    chk("t1_drain_data", out_data, Nop);
    chk("t1_drain_bubble", bubble_cnt, 1);
    out_ready = 1'b0;

    // 2: fill skid with the output stalled, then drain in order.
    in_valid = 1'b1;
    in_data  = 8'h11;
    tick();
    chk("t2_first", out_data, 8'h11);
    in_data = 8'h22;
    tick();
    chk("t2_full_in_ready", in_ready, 0);
    chk("t2_full_data", out_data, 8'h11);
    in_data = 8'h33;
    tick();
    chk("t2_stall_data", out_data, 8'h11);
    chk("t2_stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("t2_second", out_data, 8'h22);
    chk("t2_reopen_in_ready", in_ready, 1);
    tick();
    chk("t2_third", out_data, 8'h33);
    chk("t2_third_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("t2_empty", out_valid, 0);
    chk("t2_bubble", bubble_cnt, 1);
    out_ready = 1'b0;

    // 3: preload one bundle, then stream at full rate with no bubbles.
    in_valid = 1'b1;
    in_data  = 8'd0;
    tick();
    chk("t3_head", out_data, 0);
    out_ready = 1'b1;
    for (int i = 1; i < 100; i++) begin
      in_data = 8'(i);
      tick();
      chk("t3_valid", out_valid, 1);
      chk("t3_data", out_data, i);
    end
    chk("t3_in_ready", in_ready, 1);
    in_valid = 1'b0;
    tick();
    chk("t3_drained", out_valid, 0);
    chk("t3_bubble", bubble_cnt, 1);
    out_ready = 1'b0;

    // 4: flush a full stage; the same-cycle input must vanish.
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_side  = 1'b1;
    tick();
    in_data = 8'h66;
    in_side = 1'b0;
    tick();
    chk("t4_full_in_ready", in_ready, 0);
    chk("t4_full_data", out_data, 8'h55);
    chk("t4_full_side", out_side, 0);
    flush   = 1'b1;
    in_data = 8'h44;
    in_side = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t4_flush_valid", out_valid, 0);
    chk("t4_flush_data", out_data, Nop);
    chk("t4_flush_in_ready", in_ready, 1);
    chk("t4_flush_side", out_side, 0);
    tick();
    tick();
    chk("t4_no_ghost", out_valid, 0);
    chk("t4_bubble_kept", bubble_cnt, 1);

    // 5: sticky side-channel and bubble saturation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_bubble_clr", bubble_cnt, 0);
    chk("t5_bubble2_clr", bubble_cnt2, 0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    in_side  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_side   = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t5_popped", out_valid, 0);
    chk("t5_bubble0", bubble_cnt, 0);
    repeat (3) tick();
    chk("t5_side", out_side, 1);
    chk("t5_bubble3", bubble_cnt, 3);
    chk("t5_bubble2_3", bubble_cnt2, 3);
    repeat (7) tick();
    chk("t5_bubble10", bubble_cnt, 10);
    chk("t5_bubble2_sat", bubble_cnt2, 3);
    chk("t5_side_hold", out_side, 1);
    out_ready = 1'b0;

    // 6: reset while full and stalled.
    in_valid = 1'b1;
    in_data  = 8'h88;
    in_side  = 1'b1;
    tick();
    in_data = 8'h99;
    tick();
    chk("t6_full_data", out_data, 8'h88);
    rst = 1'b1;
    tick();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, Nop);
    chk("t6_rst_side", out_side, 0);
    chk("t6_rst_bubble", bubble_cnt, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    tick();
    chk("t6_rst_hold_in_ready", in_ready, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t6_release_in_ready", in_ready, 1);
    tick();
    chk("t6_no_partial", out_valid, 0);
    chk("t6_no_partial_data", out_data, Nop);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
